prime: RTL and testbench

- Sequential primality checker for a 10-bit unsigned integer (0..1023).
- Captures one operand per input_valid strobe and tests it by trial division, one divisor per clock.
- Pulses result_ready for one cycle and holds the is_prime verdict until the next operand is captured.
- Standalone datapath leaf: host supplies operand plus strobe and waits for the ready pulse.

---
 rtl/prime_if.sv | 24 ++
 rtl/prime.sv | 109 ++++++++++
 tb/tb_prime.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/prime_if.sv
// Operand/result bus for the prime checker: host drives operand and strobe,
// checker returns the ready pulse and the verdict.
interface prime_if #(
   parameter int unsigned WIDTH = 10
);
   logic [WIDTH-1:0] input_no;
   logic             input_valid;
   logic             result_ready;
   logic             is_prime;

   modport master (
      output input_no,
      output input_valid,
      input  result_ready,
      input  is_prime
   );

   modport slave (
      input  input_no,
      input  input_valid,
      output result_ready,
      output is_prime
   );
endinterface

// File: rtl/prime.sv
// Sequential trial-division primality checker, one divisor per clock.
// Optional PRIME_WHEEL_EN: 6k+-1 divisor wheel after 3 (same verdicts, lower latency).
module prime #(
   parameter int unsigned WIDTH = 10
) (
   prime_if.slave bus,
   input  logic   clock,
   input  logic   reset_n
);
   localparam int unsigned DW  = 6;
   localparam int unsigned SQW = 2 * DW;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] n_q, n_nx;
   logic [DW-1:0]    d_q, d_nx;
   logic             verdict_q, verdict_nx;
   logic             done_q;

   logic [SQW-1:0]   d_sq;
   logic [WIDTH-1:0] rem;
   logic [DW-1:0]    step;
   logic             trivial;
   logic             trivial_prime;

   // Divisor arithmetic: 12-bit square so the loop bound never wraps.
   assign d_sq = SQW'(d_q) * SQW'(d_q);
   assign rem  = (d_q == '0) ? '0 : (n_q % WIDTH'(d_q));

`ifdef PRIME_WHEEL_EN
   // 6k+1 divisors jump by 4 to skip the next multiple of 3; 3 and 6k-1 step by 2.
   assign step = ((d_q % DW'(6)) == DW'(1)) ? DW'(4) : DW'(2);
`else
   assign step = DW'(2);
`endif

   // Operands below 4 or even need no division.
   assign trivial       = (bus.input_no <= WIDTH'(3)) || !bus.input_no[0];
   assign trivial_prime = (bus.input_no == WIDTH'(2)) || (bus.input_no == WIDTH'(3));

   // Next-state and datapath update.
   always_comb begin
      state_nx   = state;
      n_nx       = n_q;
      d_nx       = d_q;
      verdict_nx = verdict_q;
      case (state)
         IDLE: begin
            if (bus.input_valid) begin
               n_nx = bus.input_no;
               d_nx = DW'(3);
               if (trivial) begin
                  verdict_nx = trivial_prime;
                  state_nx   = DONE;
               end else begin
                  state_nx = CHECK;
               end
            end
         end
         CHECK: begin
            if (d_sq > SQW'(n_q)) begin
               verdict_nx = 1'b1;
               state_nx   = DONE;
            end else if (rem == '0) begin
               verdict_nx = 1'b0;
               state_nx   = DONE;
            end else begin
               d_nx = d_q + step;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         n_q       <= '0;
         d_q       <= '0;
         verdict_q <= 1'b0;
      end else begin
         state     <= state_nx;
         n_q       <= n_nx;
         d_q       <= d_nx;
         verdict_q <= verdict_nx;
      end
   end

   // Output stage: pulse and verdict are launched one cycle after DONE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         done_q           <= 1'b0;
         bus.result_ready <= 1'b0;
         bus.is_prime     <= 1'b0;
      end else begin
         done_q           <= (state == DONE);
         bus.result_ready <= done_q;
         if (done_q) begin
            bus.is_prime <= verdict_q;
         end
      end
   end
endmodule

// File: tb/tb_prime.sv
// Bench for prime: directed plan items, exhaustive sweep and random operands
// checked against a plain-arithmetic primality and divisor-count model.
module tb_prime;
   logic clock;
   logic reset_n;
   int   checks;
   int   failures;

   prime_if #(.WIDTH(10)) bus ();

   prime #(.WIDTH(10)) dut (
      .bus     (bus),
      .clock   (clock),
      .reset_n (reset_n)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

`ifdef PRIME_WHEEL_EN
   localparam int LAT961 = 13;
`else
   localparam int LAT961 = 17;
`endif

   initial begin
      #5000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic int ref_prime(input int n);
      if (n < 2) return 0;
      for (int i = 2; i < n; i++) begin
         if (n % i == 0) return 0;
      end
      return 1;
   endfunction

   // Latency = 2 + number of divisors visited before the loop exits.
   function automatic int ref_lat(input int n);
      int divs[$];
      int k;
      if (n < 4 || n % 2 == 0) return 2;
      divs.push_back(3);
      for (int i = 5; i <= 63; i += 2) begin
`ifdef PRIME_WHEEL_EN
         if (i % 3 != 0) divs.push_back(i);
`else
         divs.push_back(i);
`endif
      end
      k = 0;
      foreach (divs[j]) begin
         k++;
         if (divs[j] * divs[j] > n) break;
         if (n % divs[j] == 0) break;
      end
      return 2 + k;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One strobe; input_no is scrambled right after capture.
   task automatic run_op(input int n, input int exp_prime, input int exp_lat, input string tag);
      int lat;
      bit seen;
      @(negedge clock);
      bus.input_no    = 10'(n);
      bus.input_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.input_valid = 1'b0;
      bus.input_no    = 10'($urandom);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clock);
         lat++;
         if (bus.result_ready === 1'b1) seen = 1'b1;
      end
      chk($sformatf("%s_n%0d_pulse", tag, n), int'(seen), 1);
      chk($sformatf("%s_n%0d_lat", tag, n), lat, exp_lat);
      chk($sformatf("%s_n%0d_prime", tag, n), int'(bus.is_prime), exp_prime);
      @(negedge clock);
      chk($sformatf("%s_n%0d_width", tag, n), int'(bus.result_ready), 0);
   endtask

   task automatic count_pulses(input int cycles, output int pulses, output int last_prime);
      pulses     = 0;
      last_prime = -1;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clock);
         if (bus.result_ready === 1'b1) begin
            pulses++;
            last_prime = int'(bus.is_prime);
         end
      end
   endtask

   initial begin
      int pulses;
      int lp;
      checks          = 0;
      failures        = 0;
      reset_n         = 1'b0;
      bus.input_no    = '0;
      bus.input_valid = 1'b0;
      #1;
      chk("reset_ready", int'(bus.result_ready), 0);
      chk("reset_prime", int'(bus.is_prime), 0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;

      // Trivial operands
      run_op(0, 0, 2, "triv");
      run_op(1, 0, 2, "triv");
      run_op(2, 1, 2, "triv");
      run_op(3, 1, 2, "triv");
      run_op(4, 0, 2, "triv");

      // Squares, primes, boundaries
      run_op(9, 0, ref_lat(9), "sq");
      run_op(25, 0, ref_lat(25), "sq");
      run_op(49, 0, ref_lat(49), "sq");
      run_op(961, 0, LAT961, "sq");
      run_op(5, 1, 3, "pr");
      run_op(97, 1, ref_lat(97), "pr");
      run_op(1021, 1, ref_lat(1021), "pr");
      run_op(1023, 0, ref_lat(1023), "pr");

      // Reset mid-check of 997 after a prime verdict is showing
      run_op(97, 1, ref_lat(97), "pre_rst");
      @(negedge clock);
      bus.input_no    = 10'd997;
      bus.input_valid = 1'b1;
      @(negedge clock);
      bus.input_valid = 1'b0;
      repeat (4) @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("midrst_ready", int'(bus.result_ready), 0);
      chk("midrst_prime", int'(bus.is_prime), 0);
      @(negedge clock);
      reset_n = 1'b1;
      count_pulses(30, pulses, lp);
      chk("midrst_no_pulse", pulses, 0);
      run_op(5, 1, 3, "post_rst");

      // Busy rejection: n=4 strobed while 997 is in CHECK
      @(negedge clock);
      bus.input_no    = 10'd997;
      bus.input_valid = 1'b1;
      @(negedge clock);
      bus.input_valid = 1'b0;
      repeat (2) @(negedge clock);
      bus.input_no    = 10'd4;
      bus.input_valid = 1'b1;
      @(negedge clock);
      bus.input_valid = 1'b0;
      count_pulses(40, pulses, lp);
      chk("busy_pulses", pulses, 1);
      chk("busy_prime", lp, 1);

      // Strobe held across several edges captures once
      @(negedge clock);
      bus.input_no    = 10'd97;
      bus.input_valid = 1'b1;
      repeat (3) @(negedge clock);
      bus.input_valid = 1'b0;
      count_pulses(30, pulses, lp);
      chk("held_pulses", pulses, 1);
      chk("held_prime", lp, 1);

      // Exhaustive sweep
      for (int n = 0; n < 1024; n++) begin
         run_op(n, ref_prime(n), ref_lat(n), "sweep");
      end

      // Random operands with random gaps
      for (int i = 0; i < 200; i++) begin
         int n;
         n = int'($urandom_range(0, 1023));
         repeat ($urandom_range(0, 3)) @(negedge clock);
         run_op(n, ref_prime(n), ref_lat(n), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
